// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Samples an asynchronous serial line at mid-bit
//            using a clocks-per-bit counter. Frames carry DATA_BITS data bits
//            (LSB first), an optional parity bit and one stop bit. The received
//            byte is held in a valid/ready register. Framing errors, parity
//            errors and overrun are reported on separate flags.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            rx         - asynchronous serial input, idles high
//            rx_ready   - consumer accepts rx_data this cycle
//            rx_data    - received byte, stable while rx_valid
//            rx_valid   - holding register full
//            frame_err  - one-cycle pulse, stop bit sampled low
//            parity_err - one-cycle pulse, parity mismatch
//            overrun    - sticky, good frame arrived while register full
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 192000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0      // 0 none, 1 odd, 2 even
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Configuration checks. Below four clocks per bit the half-bit and full-bit
  // sample points collapse together and mid-bit sampling is meaningless.
  // --------------------------------------------------------------------------
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_rx: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx: PARITY must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer. Both stages reset to the idle level so that a
  // release of reset never looks like a start edge on a quiet line.
  // --------------------------------------------------------------------------
  logic sync1;
  logic rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Parity bit the transmitter should have sent for the assembled data.
  logic par_exp;
  assign par_exp = (PARITY == 1) ? ~^shreg : ^shreg;

  // --------------------------------------------------------------------------
  // Receive state machine. The clock counter restarts on every state entry
  // and every sample, so each sample point is one full bit after the last.
  // The start sample sits at half a bit, so every following sample lands
  // in the middle of its bit cell.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      // Consumer handshake. A frame completing in this same cycle overrides
      // the clear below, so back-to-back bytes never drop rx_valid.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state   <= ST_START;
            busy    <= 1'b1;
            par_bad <= 1'b0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              // Line went back high before mid start bit: a glitch.
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
              state <= (PARITY != 0) ? ST_PAR : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PAR: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bad <= (rx_s != par_exp);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              // Framing error takes precedence over any parity mismatch.
              // Wait for the line to return high so a held-low break
              // produces one error rather than a stream of bogus frames.
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end else begin
              // Back to IDLE at mid stop bit, so a start edge arriving at
              // the nominal end of the stop bit is still caught.
              state <= ST_IDLE;
              busy  <= 1'b0;
              if (par_bad) begin
                parity_err <= 1'b1;
              end else if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Two receivers share one clock:
//            unit 0 uses the default 8N1 format, unit 1 uses even parity.
//            Stimulus tasks push expected receive events (byte presented,
//            frame error, parity error) with their expected cycle. A monitor
//            on the falling clock edge pops and compares each event the DUTs
//            present.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 20;
  // Cycle offset from driving the start bit to the result appearing:
  // 2 synchronizer clocks + half bit + remaining bit cells + 1 register.
  localparam int LAT0 = 2 + 10 + 9 * CPB + 1;    // 193, 8N1
  localparam int LAT1 = 2 + 10 + 10 * CPB + 1;   // 213, 8E1

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx0     = 1'b1;
  logic       rx1     = 1'b1;
  logic       rdy0    = 1'b0;
  logic       rdy1    = 1'b0;
  logic [7:0] data0, data1;
  logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, bz0, bz1;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int unit;
    int kind;
    int data;
    int when;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx0),
    .rx_ready   (rdy0),
    .rx_data    (data0),
    .rx_valid   (v0),
    .frame_err  (fe0),
    .parity_err (pe0),
    .overrun    (ov0),
    .busy       (bz0)
  );

  uart_rx #(.PARITY(2)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx1),
    .rx_ready   (rdy1),
    .rx_data    (data1),
    .rx_valid   (v1),
    .frame_err  (fe1),
    .parity_err (pe1),
    .overrun    (ov1),
    .busy       (bz1)
  );

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 'h%0h required 'h%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int u, input int k, input int d, input int w);
    ev_t e;
    e.unit = u;
    e.kind = k;
    e.data = d;
    e.when = w;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int u, input logic b);
    if (u == 0) rx0 = b;
    else        rx1 = b;
  endtask

  // Drives one complete frame starting in the current cycle. par < 0 means
  // no parity bit, otherwise par[0] is sent as the parity bit.
  task automatic send(input int u, input logic [7:0] d, input logic stop,
                      input int par);
    drive(u, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(u, d[i]);
      tick(CPB);
    end
    if (par >= 0) begin
      drive(u, par[0]);
      tick(CPB);
    end
    drive(u, stop);
    tick(CPB);
  endtask

  task automatic accept0();
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
  endtask

  task automatic accept1();
    rdy1 = 1'b1;
    tick(1);
    rdy1 = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  logic pv [2] = '{1'b0, 1'b0};
  logic pr [2] = '{1'b0, 1'b0};

  task automatic got_ev(input int u, input int k, input int d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got unit %0d kind %0d data 'h%0h cycle %0d, required none",
               u, k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.unit != u || e.kind != k || (k == K_DATA && e.data != d) || e.when != cyc) begin
        bad++;
        $display("FAIL event: got unit %0d kind %0d data 'h%0h cycle %0d, required unit %0d kind %0d data 'h%0h cycle %0d",
                 u, k, d, cyc, e.unit, e.kind, e.data, e.when);
      end
    end
  endtask

  // A byte is newly presented when rx_valid is high and the previous cycle
  // was not simply holding an unaccepted byte.
  task automatic mon(input int u, input logic v, input logic r, input logic fe,
                     input logic pe, input logic [7:0] d);
    if (v && !(pv[u] && !pr[u])) got_ev(u, K_DATA, int'(d));
    if (fe) got_ev(u, K_FERR, 0);
    if (pe) got_ev(u, K_PERR, 0);
    pv[u] = v;
    pr[u] = r;
  endtask

  always @(negedge clk) begin
    mon(0, v0, rdy0, fe0, pe0, data0);
    mon(1, v1, rdy1, fe1, pe1, data1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int p;
    int p2;
    int bc;
    int first;

    tick(3);
    chk("reset_valid0", v0, 0);
    chk("reset_data0", data0, 0);
    chk("reset_ferr0", fe0, 0);
    chk("reset_perr0", pe0, 0);
    chk("reset_ovr0", ov0, 0);
    chk("reset_busy0", bz0, 0);
    chk("reset_valid1", v1, 0);
    chk("reset_busy1", bz1, 0);
    chk("reset_ovr1", ov1, 0);
    reset_n = 1'b1;
    tick(5);

    // 1: basic 8N1 byte, then accept.
    p = cyc;
    push(0, K_DATA, 'hA5, p + LAT0);
    send(0, 8'hA5, 1'b1, -1);
    tick(5);
    chk("a5_data", data0, 'hA5);
    chk("a5_valid", v0, 1);
    chk("a5_ovr", ov0, 0);
    accept0();
    chk("a5_accept_clears", v0, 0);

    // 2: 6-clock glitch aborts in START.
    p     = cyc;
    bc    = 0;
    first = -1;
    rx0   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) rx0 = 1'b1;
      if (bz0 && first < 0) first = i;
      bc += int'(bz0);
      tick(1);
    end
    chk("glitch_busy_cycles", bc, 10);
    chk("glitch_busy_first", first, 3);
    chk("glitch_no_valid", v0, 0);

    // 3: stop bit low, line held low as a break, then a clean frame.
    p = cyc;
    push(0, K_FERR, 0, p + LAT0);
    send(0, 8'h3C, 1'b0, -1);
    tick(200);
    chk("break_busy", bz0, 1);
    tick(180);
    rx0 = 1'b1;
    tick(10);
    chk("break_idle", bz0, 0);
    chk("break_no_valid", v0, 0);
    p = cyc;
    push(0, K_DATA, 'h81, p + LAT0);
    send(0, 8'h81, 1'b1, -1);
    tick(2);
    chk("x81_data", data0, 'h81);
    accept0();

    // 4a: two frames back to back, nobody accepts.
    p = cyc;
    push(0, K_DATA, 'h11, p + LAT0);
    send(0, 8'h11, 1'b1, -1);
    send(0, 8'h22, 1'b1, -1);
    tick(5);
    chk("ovr_data_kept", data0, 'h11);
    chk("ovr_valid", v0, 1);
    chk("ovr_set", ov0, 1);

    // 6: reset during data bit 4 of 0xF0 (bits 4..7 and stop are high).
    rx0 = 1'b0;
    tick(5 * CPB);
    rx0 = 1'b1;
    tick(5);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", v0, 0);
    chk("rst_mid_data", data0, 0);
    chk("rst_mid_ovr", ov0, 0);
    chk("rst_mid_busy", bz0, 0);
    tick(3);
    reset_n = 1'b1;
    tick(120);
    chk("rst_no_false_start", bz0, 0);
    p = cyc;
    push(0, K_DATA, 'h5A, p + LAT0);
    send(0, 8'h5A, 1'b1, -1);
    tick(2);
    chk("x5a_data", data0, 'h5A);
    accept0();

    // 4b: accept in the same cycle the second frame completes.
    p = cyc;
    push(0, K_DATA, 'h11, p + LAT0);
    send(0, 8'h11, 1'b1, -1);
    p2 = cyc;
    push(0, K_DATA, 'h22, p2 + LAT0);
    fork
      send(0, 8'h22, 1'b1, -1);
      begin
        tick(LAT0 - 1);
        rdy0 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
      end
    join
    tick(3);
    chk("same_cycle_data", data0, 'h22);
    chk("same_cycle_valid", v0, 1);
    chk("same_cycle_no_ovr", ov0, 0);
    accept0();

    // 5: even parity unit, good then bad parity bit.
    p = cyc;
    push(1, K_DATA, 'h07, p + LAT1);
    send(1, 8'h07, 1'b1, 1);
    tick(2);
    chk("par_good_data", data1, 'h07);
    accept1();
    p = cyc;
    push(1, K_PERR, 0, p + LAT1);
    send(1, 8'h07, 1'b1, 0);
    tick(5);
    chk("par_bad_no_valid", v1, 0);
    chk("par_bad_no_ovr", ov1, 0);

    tick(5);
    chk("events_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
